// File: rtl/shared_counter_arbiter.sv
// shared_counter_arbiter: round-robin arbiter granting one requester at a time a shared up-counter
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   req       per-requester level request, held until done or abandoned
//   count_in  per-requester target, slice i = [i*WIDTH +: WIDTH], sampled at the grant edge
//   grant     one-hot current owner, zero when idle
//   grant_id  index of current owner, zero when idle
//   busy      high whenever a session is active
//   count_out shared counter value
//   done      one-cycle completion pulse to the owner
module shared_counter_arbiter #(
   parameter int NREQ = 4,
   parameter int WIDTH = 16,
   localparam int IW = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] count_in,
   output logic [NREQ-1:0]       grant,
   output logic [IW-1:0]         grant_id,
   output logic                  busy,
   output logic [WIDTH-1:0]      count_out,
   output logic [NREQ-1:0]       done
);
   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] owner_q, owner_d, last_q, last_d, win;
   logic [WIDTH-1:0] cnt_q, cnt_d, tgt_q, tgt_d;
   logic found;
   int idx;
   // search starts one past the previous owner, so a repeat requester gets lowest priority
   always_comb begin
      win = '0;
      found = 1'b0;
      idx = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_q) + k) % NREQ;
         if (!found && req[IW'(idx)]) begin
            found = 1'b1;
            win = IW'(idx);
         end
      end
   end
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d = last_q;
      cnt_d = cnt_q;
      tgt_d = tgt_q;
      case (state_q)
         IDLE: if (found) begin
            state_d = COUNT;
            owner_d = win;
            last_d = win;
            tgt_d = count_in[win*WIDTH +: WIDTH];
            cnt_d = '0;
         end
         // abandoning the request wins over reaching the target
         COUNT: if (!req[owner_q]) begin
            state_d = IDLE;
            owner_d = '0;
            cnt_d = '0;
         end else if (cnt_q != tgt_q) begin
            cnt_d = cnt_q + WIDTH'(1);
         end else begin
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
            owner_d = '0;
            cnt_d = '0;
         end
         default: begin
            state_d = IDLE;
            owner_d = '0;
            cnt_d = '0;
         end
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q <= IW'(NREQ - 1);
         cnt_q <= '0;
         tgt_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q <= last_d;
         cnt_q <= cnt_d;
         tgt_q <= tgt_d;
      end
   end
   assign busy = state_q != IDLE;
   assign grant = busy ? NREQ'(1) << owner_q : '0;
   assign grant_id = owner_q;
   assign count_out = cnt_q;
   assign done = state_q == DONE ? grant : '0;
endmodule

// File: tb/tb_shared_counter_arbiter.sv
// tb_shared_counter_arbiter: directed and random checks of shared_counter_arbiter against a session model
module tb_shared_counter_arbiter;
   localparam int N = 4;
   localparam int W = 8;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [N-1:0] req = '0;
   logic [N*W-1:0] count_in = '0;
   logic [N-1:0] grant, done;
   logic [1:0] grant_id;
   logic busy;
   logic [W-1:0] count_out;
   int checks = 0;
   int failures = 0;
   int m_owner = -1;
   int m_last = N - 1;
   int m_age = 0;
   int m_t = 0;
   shared_counter_arbiter #(.NREQ(N), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .req(req), .count_in(count_in), .grant(grant),
      .grant_id(grant_id), .busy(busy), .count_out(count_out), .done(done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask
   // session model: age counts cycles since the grant; count_out = min(age,T), done at age T+1
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_owner = -1;
         m_last = N - 1;
         m_age = 0;
         m_t = 0;
      end else if (m_owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (m_owner < 0 && req[i]) begin
               m_owner = i;
               m_last = i;
               m_age = 0;
               m_t = int'(count_in[i*W +: W]);
            end
         end
      end else if (m_age == m_t + 1 || !req[m_owner]) begin
         m_owner = -1;
      end else begin
         m_age++;
      end
   end
   always @(negedge clk) begin
      if (reset) begin
         logic [N-1:0] eg;
         eg = m_owner >= 0 ? N'(1) << m_owner : '0;
         chk("model_grant", 32'(grant), 32'(eg));
         chk("model_grant_id", 32'(grant_id), m_owner >= 0 ? 32'(m_owner) : 0);
         chk("model_busy", 32'(busy), 32'(m_owner >= 0));
         chk("model_count", 32'(count_out), m_owner < 0 ? 0 : 32'(m_age < m_t ? m_age : m_t));
         chk("model_done", 32'(done), (m_owner >= 0 && m_age == m_t + 1) ? 32'(eg) : 0);
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      req = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask
   task automatic set_t(input int i, input int t);
      count_in[i*W +: W] = W'(t);
   endtask
   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 400) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(busy), 0);
   endtask
   initial begin
      int n;
      logic [N-1:0] nr;
      do_reset();
      #1;
      chk("reset_grant", 32'(grant), 0);
      chk("reset_count", 32'(count_out), 0);
      // single requester 2, T=5
      @(negedge clk);
      set_t(2, 5);
      req = 4'b0100;
      tick();
      chk("single_grant", 32'(grant), 32'h4);
      chk("single_id", 32'(grant_id), 2);
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("single_count", 32'(count_out), 32'(k));
         chk("single_nodone", 32'(done), 0);
      end
      tick();
      chk("single_done", 32'(done), 32'h4);
      chk("single_hold", 32'(count_out), 5);
      @(negedge clk);
      req = '0;
      tick();
      chk("single_idle", 32'(busy), 0);
      // contention, all T=2
      do_reset();
      for (int i = 0; i < N; i++) set_t(i, 2);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         do begin
            tick();
            n++;
         end while (!busy && n < 10);
         chk("rr_order", 32'(grant_id), 32'(k % N));
         n = 1;
         do begin
            tick();
            if (busy) n++;
         end while (busy && n < 10);
         chk("rr_len", 32'(n), 4);
      end
      @(negedge clk);
      req = '0;
      wait_idle();
      // zero target
      do_reset();
      set_t(1, 0);
      req = 4'b0010;
      tick();
      chk("zero_grant", 32'(grant), 32'h2);
      chk("zero_count", 32'(count_out), 0);
      tick();
      chk("zero_done", 32'(done), 32'h2);
      chk("zero_count2", 32'(count_out), 0);
      @(negedge clk);
      req = '0;
      wait_idle();
      // abort at count 40 with requester 0 pending
      do_reset();
      set_t(3, 100);
      set_t(0, 3);
      req = 4'b1000;
      tick();
      chk("abort_grant", 32'(grant), 32'h8);
      @(negedge clk);
      req = 4'b1001;
      n = 0;
      while (count_out != 40 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reach40", 32'(count_out), 40);
      req = 4'b0001;
      tick();
      chk("abort_cleared", 32'(grant), 0);
      chk("abort_nodone", 32'(done), 0);
      tick();
      chk("abort_next", 32'(grant), 32'h1);
      @(negedge clk);
      req = '0;
      wait_idle();
      // asynchronous reset mid-count
      do_reset();
      set_t(0, 20);
      req = 4'b0001;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (count_out != 7 && n < 50);
      #3;
      reset = 1'b0;
      #1;
      chk("areset_grant", 32'(grant), 0);
      chk("areset_busy", 32'(busy), 0);
      chk("areset_count", 32'(count_out), 0);
      chk("areset_id", 32'(grant_id), 0);
      @(negedge clk);
      reset = 1'b1;
      req = 4'b1111;
      tick();
      chk("areset_first", 32'(grant), 32'h1);
      @(negedge clk);
      req = '0;
      wait_idle();
      // maximum target, no wrap
      do_reset();
      set_t(1, 255);
      req = 4'b0010;
      tick();
      repeat (255) tick();
      chk("max_count", 32'(count_out), 255);
      chk("max_nodone", 32'(done), 0);
      tick();
      chk("max_done", 32'(done), 32'h2);
      chk("max_hold", 32'(count_out), 255);
      @(negedge clk);
      req = '0;
      wait_idle();
      // random traffic checked by the model
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++)
            set_t(i, $urandom_range(0, 60) == 0 ? 255 : int'($urandom_range(0, 9)));
         if ($urandom_range(0, 3) == 0) begin
            nr = N'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 15) != 0) nr[m_owner] = 1'b1;
            req = nr;
         end
         if ($urandom_range(0, 500) == 0) begin
            #2;
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/shared_counter_arbiter.md
SHARED_COUNTER_ARBITER -- requirements
Module: shared_counter_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the counter (2..8).
REQ-002 Parameter WIDTH, default 16: counter and target width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester count request; level, held until done or abandoned.
REQ-006 count_in  input  NREQ*WIDTH  per-requester target T; slice i = bits [i*WIDTH +: WIDTH].
REQ-007 grant  output  NREQ  one-hot owner of the shared counter; all-zero when idle.
REQ-008 grant_id  output  clog2(NREQ)  index of current owner; 0 when idle.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 count_out  output  WIDTH  current shared counter value.
REQ-011 done  output  NREQ  one-cycle completion pulse to the owning requester.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, COUNT, DONE.
REQ-013 IDLE: if any req bit is high at a rising edge, the block SHALL select a winner, latch its count_in slice as T, set grant/grant_id, clear count_out to 0 and enter COUNT on that edge.
REQ-014 Arbitration SHALL be round-robin: search starts at (last_owner+1) mod NREQ and wraps; first set req bit wins.
REQ-015 last_owner SHALL update only on a grant.
REQ-016 COUNT: while req[owner] is high and count_out != T, count_out SHALL increment by 1 per cycle.
REQ-017 COUNT with count_out == T and req[owner] high: enter DONE on the next edge; count_out holds T.
REQ-018 DONE: done[owner] high for exactly one cycle, grant held; next edge enters IDLE, clears grant, grant_id, count_out.
REQ-019 Latency: req sampled at edge E0 -> done high during the cycle after edge E0+T+1; T=0 gives done after E0+1 with no special-casing.
REQ-020 Abort: req[owner] low at any edge in COUNT -> next state IDLE, grant cleared, count_out cleared, no done pulse.
REQ-021 In DONE, req[owner] is ignored; done SHALL still pulse.
REQ-022 count_in SHALL be sampled only at the grant edge; later changes have no effect on the running count.
REQ-023 count_out SHALL never wrap; maximum T = 2^WIDTH-1 completes normally.
REQ-024 Requests from non-owners SHALL be ignored until IDLE; re-arbitration occurs no earlier than the edge after DONE.
REQ-025 An owner keeping req high after done SHALL be eligible again but at lowest priority per REQ-014.
REQ-026 At most one done bit and one grant bit SHALL be high in any cycle; done bit index equals grant_id.

Reset
REQ-027 reset low SHALL immediately, without a clock edge, force state IDLE, grant=0, grant_id=0, busy=0, count_out=0, done=0, T=0, last_owner=NREQ-1.
REQ-028 reset asserted mid-COUNT or mid-DONE SHALL suppress any pending done pulse.
REQ-029 After reset release, the first grant with all req high SHALL go to requester 0.

Verification
REQ-030 Single: req[2]=1, T=5 -> grant=0100 one edge later, count_out 0..5, done[2] one cycle at E0+6, then idle.
REQ-031 Contention: req=1111 held, all T=2 -> grants in order 0,1,2,3,0, each lasting 4 cycles, no overlap.
REQ-032 Zero target: req[1]=1, T=0 -> done[1] after one COUNT cycle; count_out stays 0.
REQ-033 Abort: req[3] with T=100, drop req at count_out=40 -> grant cleared next edge, no done; pending req[0] granted the following edge.
REQ-034 Async reset: assert reset low between edges at count_out=7 -> all outputs 0 immediately; after release req=1111 grants 0.
REQ-035 Max target: WIDTH=4, T=15 -> count_out reaches 15, no wrap, done after 16 edges.
